// File: rtl/move_key_sched.sv
// move_key_sched: turns rising edges on the four debounced direction levels
// into latched move requests, arbitrates them round-robin and offers one move
// at a time to the game core over a valid/ready handshake.
// Optional build macro MOVE_LOCKOUT_EN adds a post-move lockout of
// LOCKOUT_CYC cycles (LOCK state plus 16-bit down-counter).
module move_key_sched #(
    parameter int unsigned LOCKOUT_CYC = 1000
) (
    input  logic       CLK,
    input  logic       ACLR,
    input  logic [3:0] KEY_IN,
    input  logic       EN,
    input  logic       MOVE_READY,
    output logic       MOVE_VALID,
    output logic [1:0] MOVE_DIR,
    output logic [3:0] PEND,
    output logic       BUSY
);

    localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYC - 1);

`ifdef MOVE_LOCKOUT_EN
    typedef enum logic [1:0] {IDLE, OFFER, LOCK} state_t;
    logic [15:0] cnt;
`else
    typedef enum logic [1:0] {IDLE, OFFER} state_t;
    // Lockout length only matters when the lockout is built.
    logic cfg_unused;
    assign cfg_unused = ^LOCK_LOAD;
`endif

    state_t     state;
    logic [1:0] ptr;
    logic [3:0] kq;
    logic [3:0] key_rise;
    logic       sel_found;
    logic [1:0] sel_dir;
    logic       grant;
    logic [3:0] grant_mask;

    assign key_rise = KEY_IN & ~kq;

    // Round-robin pick: first pending bit at ptr, ptr+1, ... (mod 4).
    always_comb begin
        logic [1:0] idx;
        sel_found = 1'b0;
        sel_dir   = 2'd0;
        idx       = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!sel_found && PEND[idx]) begin
                sel_found = 1'b1;
                sel_dir   = idx;
            end
        end
    end

    assign grant      = (state == IDLE) && EN && sel_found;
    assign grant_mask = grant ? (4'b0001 << sel_dir) : 4'b0000;

    // Previous key levels for rising-edge detection; zero after reset so a key
    // held through reset release still counts as one press.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) kq <= 4'b0000;
        else      kq <= KEY_IN;
    end

    // Pending requests: a new press beats a same-cycle grant clear; EN low
    // throws everything away.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR)     PEND <= 4'b0000;
        else if (!EN) PEND <= 4'b0000;
        else          PEND <= (PEND & ~grant_mask) | key_rise;
    end

    // Scheduler FSM with registered handshake outputs.
    always_ff @(posedge CLK or posedge ACLR) begin
        if (ACLR) begin
            state      <= IDLE;
            ptr        <= 2'd0;
            MOVE_VALID <= 1'b0;
            MOVE_DIR   <= 2'd0;
            BUSY       <= 1'b0;
`ifdef MOVE_LOCKOUT_EN
            cnt        <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        MOVE_DIR   <= sel_dir;
                        MOVE_VALID <= 1'b1;
                        BUSY       <= 1'b1;
                        state      <= OFFER;
                    end
                end
                OFFER: begin
                    // Offer is held untouched until accepted, even if EN drops.
                    if (MOVE_READY) begin
                        MOVE_VALID <= 1'b0;
                        ptr        <= MOVE_DIR + 2'd1;
`ifdef MOVE_LOCKOUT_EN
                        cnt        <= LOCK_LOAD;
                        state      <= LOCK;
`else
                        BUSY       <= 1'b0;
                        state      <= IDLE;
`endif
                    end
                end
`ifdef MOVE_LOCKOUT_EN
                LOCK: begin
                    if (cnt == 16'd0) begin
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
`endif
                default: begin
                    MOVE_VALID <= 1'b0;
                    BUSY       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_key_sched.sv
// Directed bench for move_key_sched; expectations adapt to MOVE_LOCKOUT_EN.
module tb_move_key_sched;

    localparam int LCYC = 5;
`ifdef MOVE_LOCKOUT_EN
    localparam bit LK  = 1'b1;
    localparam int GAP = LCYC + 2;
`else
    localparam bit LK  = 1'b0;
    localparam int GAP = 2;
`endif

    logic       CLK, ACLR, EN, MOVE_READY, MOVE_VALID, BUSY;
    logic [3:0] KEY_IN, PEND;
    logic [1:0] MOVE_DIR;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    move_key_sched #(.LOCKOUT_CYC(LCYC)) dut (
        .CLK(CLK), .ACLR(ACLR), .KEY_IN(KEY_IN), .EN(EN),
        .MOVE_READY(MOVE_READY), .MOVE_VALID(MOVE_VALID),
        .MOVE_DIR(MOVE_DIR), .PEND(PEND), .BUSY(BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        ACLR = 1'b1;
        tick();
        tick();
        ACLR = 1'b0;
    endtask

    // Bounded wait for an offer; at = cycle index when seen, -1 on timeout.
    task automatic wait_valid(input int maxc, output int at);
        at = -1;
        for (int i = 0; i < maxc && at < 0; i++) begin
            if (MOVE_VALID === 1'b1) at = cyc;
            else tick();
        end
        chk("offer_timeout", 32'(at >= 0), 32'd1);
    endtask

    initial begin
        int  at, prev, r1, r2, nmv;
        bit  ok;
        logic [1:0] seen_dir;

        ACLR = 1'b1; KEY_IN = 4'b0000; EN = 1'b1; MOVE_READY = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(MOVE_VALID), 32'd0);
        chk("rst_dir",   32'(MOVE_DIR),   32'd0);
        chk("rst_pend",  32'(PEND),       32'd0);
        chk("rst_busy",  32'(BUSY),       32'd0);
        ACLR = 1'b0;

        // single press of left
        KEY_IN = 4'b0100;
        tick();
        chk("sp_pend",   32'(PEND),       32'h4);
        chk("sp_valid0", 32'(MOVE_VALID), 32'd0);
        tick();
        chk("sp_valid1", 32'(MOVE_VALID), 32'd1);
        chk("sp_dir",    32'(MOVE_DIR),   32'd2);
        chk("sp_pendclr",32'(PEND),       32'd0);
        chk("sp_busy",   32'(BUSY),       32'd1);
        tick();
        chk("sp_valid2", 32'(MOVE_VALID), 32'd0);
        chk("sp_busy2",  32'(BUSY),       32'(LK));
        KEY_IN = 4'b0000;
        repeat (10) tick();

        // all four at once, round-robin from ptr 0
        do_reset();
        KEY_IN = 4'b1111;
        tick();
        chk("all_pend", 32'(PEND), 32'hF);
        prev = 0;
        for (int d = 0; d < 4; d++) begin
            wait_valid(20, at);
            chk("all_dir", 32'(MOVE_DIR), 32'(d));
            if (d > 0) chk("all_gap", 32'(at - prev), 32'(GAP));
            prev = at;
            tick();
        end
        chk("all_pend_end", 32'(PEND), 32'd0);
        chk("all_valid_end", 32'(MOVE_VALID), 32'd0);
        KEY_IN = 4'b0000;
        repeat (10) tick();

        // down + right: spacing and BUSY across the lockout
        do_reset();
        KEY_IN = 4'b1010;
        tick();
        wait_valid(20, r1);
        chk("lk_dir1", 32'(MOVE_DIR), 32'd1);
        tick();
        chk("lk_hs_valid", 32'(MOVE_VALID), 32'd0);
`ifdef MOVE_LOCKOUT_EN
        ok = 1'b1;
        for (int j = 0; j < LCYC; j++) begin
            if (BUSY !== 1'b1 || MOVE_VALID !== 1'b0) ok = 1'b0;
            tick();
        end
        chk("lk_busy_hold", 32'(ok), 32'd1);
`else
        chk("lk_busy_idle", 32'(BUSY), 32'd0);
`endif
        wait_valid(20, r2);
        chk("lk_gap", 32'(r2 - r1), 32'(GAP));
        chk("lk_dir2", 32'(MOVE_DIR), 32'd3);
        tick();
        KEY_IN = 4'b0000;
        repeat (10) tick();

        // backpressure: offer of down held 20 cycles, up pressed meanwhile
        do_reset();
        MOVE_READY = 1'b0;
        KEY_IN = 4'b0010;
        tick();
        chk("bp_pend", 32'(PEND), 32'h2);
        tick();
        chk("bp_valid", 32'(MOVE_VALID), 32'd1);
        chk("bp_dir",   32'(MOVE_DIR),   32'd1);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 3) KEY_IN = 4'b0011;
            tick();
            if (MOVE_VALID !== 1'b1 || MOVE_DIR !== 2'd1) ok = 1'b0;
        end
        chk("bp_stable", 32'(ok), 32'd1);
        chk("bp_pend_up", 32'(PEND), 32'h1);
        MOVE_READY = 1'b1;
        tick();
        chk("bp_hs_valid", 32'(MOVE_VALID), 32'd0);
        chk("bp_hs_pend",  32'(PEND),       32'h1);
        wait_valid(20, at);
        chk("bp_next_dir", 32'(MOVE_DIR), 32'd0);
        tick();
        KEY_IN = 4'b0000;
        repeat (10) tick();

        // EN low discards presses and blocks new grants
        do_reset();
        EN = 1'b0;
        KEY_IN = 4'b0100;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (PEND !== 4'b0000 || MOVE_VALID !== 1'b0) ok = 1'b0;
        end
        chk("en_discard", 32'(ok), 32'd1);
        KEY_IN = 4'b0000;
        EN = 1'b1;
        repeat (3) tick();
        chk("en_pend_after", 32'(PEND), 32'd0);
        chk("en_valid_after", 32'(MOVE_VALID), 32'd0);
        // offer in flight survives EN dropping
        MOVE_READY = 1'b0;
        KEY_IN = 4'b0001;
        tick();
        tick();
        chk("en_fl_valid", 32'(MOVE_VALID), 32'd1);
        EN = 1'b0;
        KEY_IN = 4'b0101;
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (MOVE_VALID !== 1'b1 || MOVE_DIR !== 2'd0 || PEND !== 4'b0000) ok = 1'b0;
        end
        chk("en_fl_hold", 32'(ok), 32'd1);
        MOVE_READY = 1'b1;
        tick();
        repeat (3) tick();
        chk("en_fl_nogrant", 32'(MOVE_VALID), 32'd0);
        EN = 1'b1;
        KEY_IN = 4'b0000;
        repeat (10) tick();

        // reset mid-offer, key held through release
        do_reset();
        MOVE_READY = 1'b0;
        KEY_IN = 4'b0101;
        tick();
        tick();
        chk("ar_valid", 32'(MOVE_VALID), 32'd1);
        chk("ar_pend",  32'(PEND),       32'h4);
        ACLR = 1'b1;
        KEY_IN = 4'b0100;
        #1;
        chk("ar_valid_rst", 32'(MOVE_VALID), 32'd0);
        chk("ar_pend_rst",  32'(PEND),       32'd0);
        chk("ar_busy_rst",  32'(BUSY),       32'd0);
        tick();
        tick();
        ACLR = 1'b0;
        MOVE_READY = 1'b1;
        nmv = 0;
        seen_dir = 2'd0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (MOVE_VALID === 1'b1) begin
                nmv++;
                seen_dir = MOVE_DIR;
            end
        end
        chk("ar_one_move", 32'(nmv), 32'd1);
        chk("ar_move_dir", 32'(seen_dir), 32'd2);
        KEY_IN = 4'b0000;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
